// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding and the
// fetch entry bundle passed from fetch to decode.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO built as a shift register so the head
// is always entry 0, a plain register with no read mux.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    widx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // A same-cycle pop shifts everything down, so the tail slot moves too
    assign widx    = do_pop ? count - CW'(1) : count;
    assign head    = mem[0];

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = mem[i+1];
        end
        shifted[DEPTH-1] = mem[DEPTH-1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && widx == CW'(i)) begin
                mem[i] <= wdata;
            end else if (do_pop) begin
                mem[i] <= shifted[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC register, imem address, redirect
// handling and a registered fetch buffer feeding decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0]          pc;
    fetch_entry_t               wentry;
    fetch_entry_t               head;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       unused_count;

    assign imem_addr    = pc;
    assign pop          = out_valid & out_ready;
    // Redirect beats everything; a full buffer still accepts when draining
    assign push         = ~redirect_valid & (~full | pop);
    assign wentry       = '{pc: pc, inst: imem_data};
    assign unused_count = ^count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = ~empty;
    assign out_inst  = empty ? NOP_INST : head.inst;
    assign out_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    int total = 0;
    int bad = 0;

    logic [7:0]   img [256];
    fetch_entry_t mq [$];
    logic [7:0]   mpc = 8'h00;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {img[a], img[a+8'd1], img[a+8'd2], img[a+8'd3]};
    endfunction

    always_comb imem_data = word(imem_addr);

    // Drive one cycle of inputs, advance the model on the edge
    task automatic step(input logic r, input logic rv,
                        input logic [7:0] rp, input logic rdy);
        int           sz;
        bit           mpop;
        fetch_entry_t e;
        rst_n = r;
        redirect_valid = rv;
        redirect_pc = rp;
        out_ready = rdy;
        @(posedge clk);
        sz = mq.size();
        mpop = (sz != 0) && rdy;
        if (!r) begin
            mq.delete();
            mpc = 8'h00;
        end else if (rv) begin
            mq.delete();
            mpc = {rp[7:2], 2'b00};
        end else begin
            if (mpop) void'(mq.pop_front());
            if (sz < 2 || mpop) begin
                e.pc = mpc;
                e.inst = word(mpc);
                mq.push_back(e);
                mpc = mpc + 8'd4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h80, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_inst !== 32'h00000013) begin
            bad++; $display("FAIL reset_inst got=%h want=00000013", out_inst);
        end
        total++;
        if (out_pc !== 8'h00) begin
            bad++; $display("FAIL reset_pc got=%h want=00", out_pc);
        end
        total++;
        if (imem_addr !== 8'h00) begin
            bad++; $display("FAIL reset_addr got=%h want=00", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h00002083;
        exp_inst[1] = 32'h0000E233;
        exp_inst[2] = 32'h00402623;
        exp_inst[3] = 32'h00000000;
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 8'(4 * k)
                || out_inst !== exp_inst[k]) begin
                bad++;
                $display("FAIL stream[%0d] got=%b/%h/%h want=1/%h/%h",
                         k, out_valid, out_pc, out_inst, 8'(4 * k), exp_inst[k]);
            end
            step(1, 0, 8'h00, 1);
        end
    endtask

    task automatic test_stall();
        step(0, 0, 8'h00, 0);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 8'h00, 0);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 8'h00
                || out_inst !== 32'h00002083) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%h want=1/00/00002083",
                         k, out_valid, out_pc, out_inst);
            end
        end
        total++;
        if (imem_addr !== 8'h08) begin
            bad++; $display("FAIL stall_pc got=%h want=08", imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 8'(4 * k)) begin
                bad++;
                $display("FAIL drain[%0d] got=%b/%h want=1/%h",
                         k, out_valid, out_pc, 8'(4 * k));
            end
            step(1, 0, 8'h00, 1);
        end
    endtask

    task automatic test_redirect();
        step(0, 0, 8'h00, 0);
        repeat (3) step(1, 0, 8'h00, 0);
        step(1, 1, 8'h40, 0);
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 8'h40) begin
            bad++;
            $display("FAIL redir_flush got=%b/%h want=0/40", out_valid, imem_addr);
        end
        step(1, 0, 8'h00, 0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40) begin
            bad++;
            $display("FAIL redir_target got=%b/%h want=1/40", out_valid, out_pc);
        end
        step(1, 0, 8'h00, 1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 8'h44) begin
            bad++;
            $display("FAIL redir_next got=%b/%h want=1/44", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        step(1, 1, 8'hF8, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_flush got=%b want=0", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 8'h00, 1);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 8'(8'hF8 + 8'(4 * k))) begin
                bad++;
                $display("FAIL wrap[%0d] got=%b/%h want=1/%h",
                         k, out_valid, out_pc, 8'(8'hF8 + 8'(4 * k)));
            end
        end
    endtask

    task automatic test_misaligned();
        step(1, 1, 8'h43, 1);
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 8'h40) begin
            bad++;
            $display("FAIL misal_flush got=%b/%h want=0/40", out_valid, imem_addr);
        end
        step(1, 0, 8'h00, 1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40) begin
            bad++;
            $display("FAIL misal_target got=%b/%h want=1/40", out_valid, out_pc);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'h00000013
            || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL midreset got=%b/%h/%h want=0/00000013/00",
                     out_valid, out_inst, imem_addr);
        end
        step(1, 0, 8'h00, 0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00
            || out_inst !== 32'h00002083) begin
            bad++;
            $display("FAIL midreset_restart got=%b/%h/%h want=1/00/00002083",
                     out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_random();
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] einst;
        logic        r, rv, rdy;
        logic [7:0]  rp;
        for (int n = 0; n < 400; n++) begin
            ev = (mq.size() != 0);
            epc = ev ? mq[0].pc : 8'h00;
            einst = ev ? mq[0].inst : 32'h00000013;
            total++;
            if (out_valid !== ev || out_pc !== epc || out_inst !== einst
                || imem_addr !== mpc) begin
                bad++;
                $display("FAIL rand[%0d] got=%b/%h/%h/%h want=%b/%h/%h/%h",
                         n, out_valid, out_pc, out_inst, imem_addr,
                         ev, epc, einst, mpc);
            end
            r = ($urandom_range(0, 39) != 0);
            rv = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            rp = $urandom_range(0, 1) ? 8'($urandom_range(0, 12))
                                      : 8'($urandom);
            step(r, rv, rp, rdy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[2] = 8'h20;  img[3] = 8'h83;
        img[6] = 8'hE2;  img[7] = 8'h33;
        img[9] = 8'h40;  img[10] = 8'h26; img[11] = 8'h23;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
